// File: rtl/hashcheck_feeder.sv
// Feeder in front of the 128-entry hash checker: loads targets, queues candidates and runs
// the checker handshake one transaction at a time, reporting matches as one-cycle pulses.
//
// state      | meaning
// -----------+-----------------------------------------------------------------
// S_SYNC     | ignore checker until chk_resultrdy has been low 12 cycles
// S_IDLE     | accept a target load (priority) or pop a queued candidate
// S_REQ      | one-cycle chk_newrdy / chk_checkrdy pulse
// S_WAIT_RES | wait for chk_resultrdy, abort after TIMEOUT cycles
// S_WAIT_LOW | wait for chk_resultrdy to drop before the next request
module hashcheck_feeder #(
    parameter int TAG_W   = 32,
    parameter int FIFO_AW = 2,
    parameter int TIMEOUT = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_valid,
    input  logic [127:0]       load_hash,
    output logic               load_ready,
    input  logic               cand_valid,
    input  logic [127:0]       cand_hash,
    input  logic [TAG_W-1:0]   cand_tag,
    output logic               cand_ready,
    output logic               chk_newrdy,
    output logic               chk_checkrdy,
    output logic [127:0]       chk_hash,
    input  logic               chk_resultrdy,
    input  logic               chk_matchfound,
    output logic               match_valid,
    output logic [TAG_W-1:0]   match_tag,
    output logic [127:0]       match_hash,
    output logic [7:0]         loaded_count,
    output logic               busy,
    output logic               timeout_err
);

    localparam int         DEPTH    = 1 << FIFO_AW;
    localparam int         TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [3:0] SYNC_LOW = 4'd11;

    typedef enum logic [2:0] {
        S_SYNC,
        S_IDLE,
        S_REQ,
        S_WAIT_RES,
        S_WAIT_LOW
    } state_t;

    state_t             state;
    logic               kind_chk;
    logic [TAG_W-1:0]   cur_tag;
    logic [TMR_W-1:0]   timer;
    logic [3:0]         sync_left;
    logic               zero_loaded;
    logic               alive;

    logic [127:0]       fifo_hash [DEPTH];
    logic [TAG_W-1:0]   fifo_tag  [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   fifo_cnt;

    logic table_full;
    logic load_fire;
    logic push;
    logic pop;
    logic hash_zero;
    logic zero_blocks;

    assign table_full  = (loaded_count == 8'd128);
    assign load_ready  = (state == S_IDLE) && !table_full;
    assign cand_ready  = !fifo_cnt[FIFO_AW];
    assign load_fire   = load_valid && load_ready;
    assign push        = cand_valid && cand_ready;
    assign pop         = (state == S_IDLE) && !load_fire && (fifo_cnt != '0);
    assign hash_zero   = (chk_hash == '0);
    // Unfilled checker slots read as zero, so a zero candidate only counts once a real zero is stored.
    assign zero_blocks = hash_zero && !zero_loaded && !table_full;
    // Held low through reset and its first cycle so the reset value is 0 even though SYNC is busy.
    assign busy        = alive && ((state != S_IDLE) || (fifo_cnt != '0));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_hash[wr_ptr] <= cand_hash;
            fifo_tag[wr_ptr]  <= cand_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_SYNC;
            sync_left    <= SYNC_LOW;
            timer        <= '0;
            kind_chk     <= 1'b0;
            cur_tag      <= '0;
            chk_hash     <= '0;
            chk_newrdy   <= 1'b0;
            chk_checkrdy <= 1'b0;
            match_valid  <= 1'b0;
            match_tag    <= '0;
            match_hash   <= '0;
            loaded_count <= '0;
            zero_loaded  <= 1'b0;
            timeout_err  <= 1'b0;
            alive        <= 1'b0;
        end else begin
            alive        <= 1'b1;
            chk_newrdy   <= 1'b0;
            chk_checkrdy <= 1'b0;
            match_valid  <= 1'b0;
            case (state)
                S_SYNC: begin
                    if (chk_resultrdy) begin
                        sync_left <= SYNC_LOW;
                    end else if (sync_left == '0) begin
                        state <= S_IDLE;
                    end else begin
                        sync_left <= sync_left - 1'b1;
                    end
                end
                S_IDLE: begin
                    if (load_fire) begin
                        chk_hash   <= load_hash;
                        kind_chk   <= 1'b0;
                        chk_newrdy <= 1'b1;
                        state      <= S_REQ;
                    end else if (pop) begin
                        chk_hash     <= fifo_hash[rd_ptr];
                        cur_tag      <= fifo_tag[rd_ptr];
                        kind_chk     <= 1'b1;
                        chk_checkrdy <= 1'b1;
                        state        <= S_REQ;
                    end
                end
                S_REQ: begin
                    timer <= TMR_W'(TIMEOUT - 1);
                    state <= S_WAIT_RES;
                end
                S_WAIT_RES: begin
                    if (chk_resultrdy) begin
                        if (!kind_chk) begin
                            if (!table_full) loaded_count <= loaded_count + 8'd1;
                            if (hash_zero)   zero_loaded  <= 1'b1;
                        end else if (chk_matchfound && !zero_blocks) begin
                            match_valid <= 1'b1;
                            match_tag   <= cur_tag;
                            match_hash  <= chk_hash;
                        end
                        state <= S_WAIT_LOW;
                    end else if (timer == '0) begin
                        timeout_err <= 1'b1;
                        sync_left   <= SYNC_LOW;
                        state       <= S_SYNC;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_WAIT_LOW: begin
                    if (!chk_resultrdy) state <= S_IDLE;
                end
                default: begin
                    sync_left <= SYNC_LOW;
                    state     <= S_SYNC;
                end
            endcase
        end
    end

endmodule
